// File: rtl/shift_unit_seq.sv
// Iterative multi-mode shifter: one bit position per clock,
// valid/ready on both sides, one operation in flight.
module shift_unit_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amount,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [1:0]       mode_q;
  logic             live;
  logic [WIDTH-1:0] step;

  always_comb begin
    step = out;
    unique case (mode_q)
      M_LSL: step = {out[WIDTH-2:0], 1'b0};
      M_LSR: step = {1'b0, out[WIDTH-1:1]};
      M_ASR: step = {out[WIDTH-1], out[WIDTH-1:1]};
      M_ROL: step = {out[WIDTH-2:0], out[WIDTH-1]};
    endcase
  end

  // live holds in_ready low for the first cycle after reset release
  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      cnt    <= '0;
      mode_q <= M_LSL;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            out    <= data;
            cnt    <= amount;
            mode_q <= mode;
            state  <= (amount != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          out <= step;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
